// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and constants for the instruction-fetch stage
//   XLEN           : machine word / address width
//   PC_STEP        : sequential fetch increment
//   ifetch_entry_t : one fetch-buffer slot {pc, instr, filled}
package ifetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } ifetch_entry_t;
endpackage

// File: rtl/ifetch_buf.sv
// ifetch_buf: in-order ring of fetch entries
//   clk, reset          : clock, synchronous active-high reset
//   alloc, alloc_pc     : claim the tail entry (unfilled) for a request at alloc_pc
//   fill, fill_data     : write an instruction into the oldest unfilled entry
//   pop                 : consume the head entry when it is filled
//   flush               : drop every entry
//   head                : current head entry
//   count, pend         : allocated entries / allocated entries still awaiting data
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            alloc,
    input  logic [XLEN-1:0] alloc_pc,
    input  logic            fill,
    input  logic [XLEN-1:0] fill_data,
    input  logic            pop,
    input  logic            flush,
    output ifetch_entry_t   head,
    output logic [CW-1:0]   count,
    output logic [CW-1:0]   pend
);
    ifetch_entry_t ents [DEPTH];
    logic [AW-1:0] hd, tl, fp;
    logic do_fill, do_pop;

    assign head = ents[hd];
    // A fill with nothing pending would corrupt a free slot, so it is ignored.
    assign do_fill = fill && pend != '0;
    assign do_pop = pop && ents[hd].filled;

    // Alloc (tail), fill (fp) and pop (hd) never hit the same slot in one cycle:
    // tail is always free, fp is always unfilled, and hd is popped only when filled.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            for (int i = 0; i < DEPTH; i++) ents[i] <= '0;
            hd <= '0;
            tl <= '0;
            fp <= '0;
            count <= '0;
            pend <= '0;
        end else begin
            if (alloc) begin
                ents[tl] <= '{pc: alloc_pc, instr: '0, filled: 1'b0};
                tl <= tl + AW'(1);
            end
            if (do_fill) begin
                ents[fp].instr <= fill_data;
                ents[fp].filled <= 1'b1;
                fp <= fp + AW'(1);
            end
            if (do_pop) begin
                ents[hd].filled <= 1'b0;
                hd <= hd + AW'(1);
            end
            count <= count + CW'(alloc) - CW'(do_pop);
            pend <= pend + CW'(alloc) - CW'(do_fill);
        end
    end
endmodule

// File: rtl/ifetch.sv
// ifetch: instruction-fetch stage around the pc register (optional macro IFETCH_ALIGN_CHECK_EN)
//   clk, reset            : clock, synchronous active-high reset
//   pc / next_pc          : current pc and the value the pc register loads next
//   redirect_valid/_pc    : branch/jump/trap redirect from execute
//   imem_req_*            : in-order read requests at pc
//   imem_resp_*           : in-order read responses, latency >= 1
//   if_valid/_ready       : handshake toward decode carrying if_instr/if_pc
//   if_misaligned         : sticky misaligned-redirect flag (IFETCH_ALIGN_CHECK_EN only)
module ifetch
    import ifetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int BUF_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_instr,
    output logic [XLEN-1:0] if_pc
`ifdef IFETCH_ALIGN_CHECK_EN
    ,
    output logic            if_misaligned
`endif
);
    localparam int CW = $clog2(BUF_DEPTH) + 1;

    ifetch_entry_t head;
    logic [CW-1:0] count, pend, drop;
    logic [CW:0] used;
    logic [XLEN-1:0] target;
    logic halt, fire, drop_hit;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic misaligned;
    assign target = redirect_pc;
    assign halt = misaligned;
    assign if_misaligned = misaligned;
    always_ff @(posedge clk)
        misaligned <= reset ? 1'b0 : redirect_valid ? |redirect_pc[1:0] : misaligned;
`else
    assign target = redirect_pc & ~(PC_STEP - 32'd1);
    assign halt = 1'b0;
`endif

    // Outstanding requests that will still return data occupy capacity too.
    assign used = {1'b0, count} + {1'b0, drop};
    assign imem_req_valid = !reset && !redirect_valid && !halt && used < (CW+1)'(BUF_DEPTH);
    assign imem_req_addr = pc;
    assign fire = imem_req_valid && imem_req_ready;
    assign next_pc = reset ? RESET_PC : redirect_valid ? target : fire ? pc + PC_STEP : pc;
    assign drop_hit = imem_resp_valid && drop != '0;

    // On a redirect every unfilled entry becomes a response to discard; a
    // response landing in that same cycle is itself discarded right away.
    always_ff @(posedge clk) begin
        if (reset)
            drop <= '0;
        else if (redirect_valid)
            drop <= drop + pend - CW'(imem_resp_valid && (drop != '0 || pend != '0));
        else
            drop <= drop - CW'(drop_hit);
    end

    ifetch_buf #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk       (clk),
        .reset     (reset),
        .alloc     (fire),
        .alloc_pc  (pc),
        .fill      (imem_resp_valid && drop == '0 && !redirect_valid),
        .fill_data (imem_resp_data),
        .pop       (if_ready),
        .flush     (redirect_valid),
        .head      (head),
        .count     (count),
        .pend      (pend)
    );

    assign if_valid = !reset && head.filled;
    assign if_instr = reset ? '0 : head.instr;
    assign if_pc = reset ? '0 : head.pc;
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed scoreboard bench for ifetch with a fixed-latency memory model
module tb_ifetch;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc, next_pc, redirect_pc, imem_req_addr, imem_resp_data, if_instr, if_pc;
    logic        redirect_valid, imem_req_valid, imem_req_ready, imem_resp_valid, if_valid, if_ready;
`ifdef IFETCH_ALIGN_CHECK_EN
    logic        if_misaligned;
`endif

    int checks = 0;
    int errors = 0;
    int fires = 0;
    int dlv = 0;
    int lat = 1;
    int f0, d0;
    logic [31:0] exp_q [$];
    logic [31:0] exp_pc;
    logic [7:0]  vp;
    logic [31:0] ap [8];

    always #5 clk = ~clk;

    ifetch dut (
        .clk             (clk),
        .reset           (reset),
        .pc              (pc),
        .next_pc         (next_pc),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc)
`ifdef IFETCH_ALIGN_CHECK_EN
        ,
        .if_misaligned   (if_misaligned)
`endif
    );

    // pc register
    always_ff @(posedge clk) pc <= next_pc;

    // Memory: fixed latency, in order, instruction word = ~address
    assign imem_resp_valid = vp[0];
    assign imem_resp_data = ~ap[0];
    always_ff @(posedge clk) begin
        for (int i = 0; i < 7; i++) ap[i] <= ap[i+1];
        vp <= reset ? 8'd0 : {1'b0, vp[7:1]};
        if (!reset && imem_req_valid && imem_req_ready) begin
            vp[lat-1] <= 1'b1;
            ap[lat-1] <= imem_req_addr;
        end
    end

    always_ff @(posedge clk) if (imem_req_valid && imem_req_ready) fires <= fires + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!reset && if_valid && if_ready) begin
            checks++;
            dlv++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got pc %h instr %h, expected no delivery", if_pc, if_instr);
            end else begin
                exp_pc = exp_q.pop_front();
                if (if_pc !== exp_pc || if_instr !== ~exp_pc) begin
                    errors++;
                    $display("FAIL sb_deliver: got pc %h instr %h, expected pc %h instr %h",
                             if_pc, if_instr, exp_pc, ~exp_pc);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        if_ready = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_next_pc", next_pc, 32'h0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'h0);
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);

        // 1-cycle memory, decode always ready: 5 requests, deliveries 2 cycles later
        nxt();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
        for (int k = 0; k < 8; k++) begin
            if (k > 0) nxt();
            if (k == 5) imem_req_ready = 1'b0;
            @(negedge clk);
            if (k < 5) begin
                chk("a_req_addr", imem_req_addr, 32'(4 * k));
                chk("a_next_pc", next_pc, 32'(4 * k + 4));
            end
            chk("a_if_valid", 32'(if_valid), (k >= 2 && k <= 6) ? 32'h1 : 32'h0);
            if (k >= 2 && k <= 6) chk("a_if_pc", if_pc, 32'(4 * (k - 2)));
        end

        // Decode stalled for 10 cycles: buffer fills with 4 and issue stops
        nxt();
        reset = 1'b1;
        if_ready = 1'b0;
        nxt();
        nxt();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        f0 = fires;
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("b_fires", 32'(fires - f0), 32'd4);
        chk("b_req_valid", 32'(imem_req_valid), 32'h0);
        chk("b_next_pc", next_pc, 32'd16);
        for (int k = 0; k < 4; k++) exp_q.push_back(32'(4 * k));
        d0 = dlv;
        nxt();
        if_ready = 1'b1;
        imem_req_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("b_drained", 32'(dlv - d0), 32'd4);

        // 3-cycle memory, redirect with two requests in flight
        nxt();
        reset = 1'b1;
        lat = 3;
        nxt();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        exp_q.push_back(32'h100);
        exp_q.push_back(32'h104);
        exp_q.push_back(32'h108);
        nxt();
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        @(negedge clk);
        chk("c_req_valid_redir", 32'(imem_req_valid), 32'h0);
        chk("c_next_pc", next_pc, 32'h100);
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("c_req_valid_after", 32'(imem_req_valid), 32'h1);
        chk("c_req_addr", imem_req_addr, 32'h100);
        nxt();
        nxt();
        nxt();
        imem_req_ready = 1'b0;
        repeat (6) @(posedge clk);

        // Redirect with a response and a handshake in the same cycle
        nxt();
        reset = 1'b1;
        lat = 1;
        nxt();
        reset = 1'b0;
        imem_req_ready = 1'b1;
        nxt();
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h40);
        exp_q.push_back(32'h44);
        @(negedge clk);
        chk("d_if_valid", 32'(if_valid), 32'h1);
        chk("d_next_pc", next_pc, 32'h40);
        nxt();
        redirect_valid = 1'b0;
        nxt();
        nxt();
        imem_req_ready = 1'b0;
        repeat (5) @(posedge clk);

        // PC wrap from 0xFFFF_FFFC
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.push_back(32'hFFFF_FFFC);
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("e_req_addr", imem_req_addr, 32'hFFFF_FFFC);
        chk("e_next_pc_wrap", next_pc, 32'h0);
        nxt();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("e_next_pc_hold", next_pc, 32'h0);
        repeat (4) @(posedge clk);

`ifdef IFETCH_ALIGN_CHECK_EN
        // Misaligned redirect halts issue until an aligned redirect
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        imem_req_ready = 1'b1;
        nxt();
        redirect_valid = 1'b0;
        f0 = fires;
        @(negedge clk);
        chk("f_misaligned_set", 32'(if_misaligned), 32'h1);
        chk("f_req_halted", 32'(imem_req_valid), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        exp_q.push_back(32'h200);
        @(negedge clk);
        chk("f_no_fires", 32'(fires - f0), 32'h0);
        nxt();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("f_misaligned_clr", 32'(if_misaligned), 32'h0);
        chk("f_req_valid", 32'(imem_req_valid), 32'h1);
        chk("f_req_addr", imem_req_addr, 32'h200);
        nxt();
        imem_req_ready = 1'b0;
        repeat (4) @(posedge clk);
`else
        // Misaligned redirect target is forced to word alignment
        nxt();
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        exp_q.push_back(32'h100);
        @(negedge clk);
        chk("f_next_pc_align", next_pc, 32'h100);
        nxt();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        chk("f_req_addr", imem_req_addr, 32'h100);
        nxt();
        imem_req_ready = 1'b0;
        repeat (4) @(posedge clk);
`endif

        @(negedge clk);
        chk("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage sitting directly around the `pc` register. It computes `next_pc` for the `pc` register, issues in-order instruction-memory reads at the current `pc`, and buffers returned instructions with their PCs. Buffered instructions go to decode over a valid/ready handshake. It also handles redirects (branch/jump/trap) by flushing buffered entries and discarding responses still in flight.

## Interface
- `RESET_PC`, 32'h0000_0000, reset fetch address; the `pc` register must reset to the same value
- `BUF_DEPTH`, 4, entries in the fetch buffer (power of two, ≥2); also the maximum outstanding-plus-buffered count

- `clk` input 1: the single clock, rising-edge
- `reset` input 1: synchronous, active-high
- `pc` input 32: current PC from the `pc` register
- `next_pc` output 32: value the `pc` register loads at the next rising edge
- `redirect_valid` input 1: redirect request from execute
- `redirect_pc` input 32: redirect target
- `imem_req_valid` output 1: read request valid
- `imem_req_ready` input 1: memory accepts the request
- `imem_req_addr` output 32: read address, equal to `pc`
- `imem_resp_valid` input 1: read data valid; responses are in order, latency ≥1
- `imem_resp_data` input 32: instruction word
- `if_valid` output 1: instruction available to decode
- `if_ready` input 1: decode accepts
- `if_instr` output 32: instruction
- `if_pc` output 32: PC of `if_instr`
- `if_misaligned` output 1: present only with `IFETCH_ALIGN_CHECK_EN`

## Operation
- **State.** The buffer is a ring of `BUF_DEPTH` entries, each holding {pc, instr, filled}.
  - `count` is the number of allocated entries.
  - `drop` is the number of in-flight responses still to be discarded.
- **Issue.** `imem_req_valid = !reset && !redirect_valid && (count + drop < BUF_DEPTH)`.
- **Request fire** (`imem_req_valid && imem_req_ready`):
  - allocate the tail entry with pc=`pc` and filled=0;
  - `next_pc = pc + 4`, mod 2^32, wrapping from 32'hFFFF_FFFC to 0.
- **No fire:** `next_pc = pc`.
- **Redirect has priority:** `next_pc = redirect_pc`.
- **Response** with `drop > 0`: discard it and decrement `drop`.
- **Response** otherwise: write `imem_resp_data` into the oldest unfilled entry and set filled.
- **Delivery.** `if_valid` is the head entry's filled bit. On `if_valid && if_ready`, pop the head.
- **Redirect cycle.**
  - No request is issued.
  - A handshake in the same cycle still completes.
  - All entries are then cleared, so `count` becomes 0.
  - `drop` becomes `drop + (unfilled entries) − imem_resp_valid`. A response arriving in this cycle is discarded.
- **Reset.** Clears all entries, `count`, and `drop`.
  - Outputs during and after reset: `next_pc = RESET_PC`, `imem_req_valid = 0`, `if_valid = 0`, `if_instr = 0`, `if_pc = 0`, `if_misaligned = 0`.
  - Reset overrides a simultaneous redirect and response. Responses to requests issued before reset are the memory's responsibility to squash.
- **Arithmetic.** All PC arithmetic is 32-bit unsigned with no saturation.

## Timing
- `imem_req_valid` and `next_pc` are combinational from `pc`, `redirect_valid`, `imem_req_ready`, and registered state.
- There is no combinational path from `if_ready` or `imem_resp_*` to any output.
- `if_valid` rises the cycle after the response.
  - With 1-cycle memory, request→`if_valid` is 2 cycles.
  - An entry is freed at count update L+2 cycles after allocation.
- Full throughput (one instruction per cycle) holds for memory latency L ≤ `BUF_DEPTH` − 2.
- After a redirect in cycle t, the first request to `redirect_pc` is issued in cycle t+1.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` **defined:**
  - A redirect with `redirect_pc[1:0] != 0` sets `if_misaligned` (registered, visible next cycle).
  - Issue then halts (`imem_req_valid = 0`) until a redirect with an aligned target.
  - That aligned redirect clears `if_misaligned` in the same edge.
- `IFETCH_ALIGN_CHECK_EN` **undefined:**
  - The `if_misaligned` port is absent.
  - `next_pc` on redirect is `{redirect_pc[31:2], 2'b00}`.

## Structure
- Package `ifetch_pkg`:
  - `XLEN = 32`;
  - `ifetch_entry_t` struct {pc, instr, filled};
  - `PC_STEP = 4`.
- Sub-module `ifetch_buf` contains:
  - the entry ring: head/tail/fill pointers, `count`;
  - ports for alloc, fill, pop, and flush.
- Top `ifetch` keeps the issue logic, the `drop` counter, `next_pc`, and the alignment check.

## Test plan
- **Reset release, 1-cycle memory, `if_ready` = 1:**
  - `next_pc` sequence 0,4,8,…;
  - `if_pc` = 0,4,8,12,16 on consecutive cycles starting 2 cycles after the first request.
- **`if_ready` = 0 for 10 cycles:**
  - exactly 4 requests are issued, then `imem_req_valid` = 0 and `next_pc` holds at 16;
  - on release, PCs 0..12 drain in order with no loss or duplication.
- **3-cycle memory, redirect to 32'h100 while 2 requests are in flight:**
  - both stale responses are discarded;
  - the next `if_pc` is 32'h100.
- **Redirect with a response and a handshake in the same cycle:**
  - the handshake completes;
  - the response is dropped and `drop` does not go negative.
- **`pc` = 32'hFFFF_FFFC with a request fire:** `next_pc` = 0.
- **With `IFETCH_ALIGN_CHECK_EN`:**
  - redirect to 32'h102 → `if_misaligned` = 1 and no requests;
  - redirect to 32'h200 → flag clears and fetch resumes at 32'h200.
